// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared encodings and sizing helpers for the iterative multiplier
// Contents: funct encodings (mul_funct_e), FSM states (mul_state_e),
//           default widths and the iteration-count helper.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,   // MUL    : low half, sign irrelevant
        MUL_HSS = 2'b01,   // MULH   : high half, signed x signed
        MUL_HSU = 2'b10,   // MULHSU : high half, signed x unsigned
        MUL_HUU = 2'b11    // MULHU  : high half, unsigned x unsigned
    } mul_funct_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    localparam int MUL_XLEN_DEF = 32;
    localparam int MUL_BPC_DEF  = 2;

    function automatic int mul_iters(input int xlen, input int bpc);
        return xlen / bpc;
    endfunction

    localparam int MUL_ITERS_DEF = MUL_XLEN_DEF / MUL_BPC_DEF;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one radix-2^BITS_PER_CYCLE shift-add step
// Ports: acc (2*XLEN accumulator in), mcand (pre-shifted multiplicand),
//        mbits (low multiplier bits), acc_next (accumulator out). Purely combinational.
module mul_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [2*XLEN-1:0]         acc,
    input  logic [2*XLEN-1:0]         mcand,
    input  logic [BITS_PER_CYCLE-1:0] mbits,
    output logic [2*XLEN-1:0]         acc_next
);

    // Adds mcand * mbits as a sum of shifted copies, avoiding a full multiplier.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mbits[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/mul_iter_unit.sv
// rtl/mul_iter_unit.sv - iterative RV32M multiply unit with EX-stage stall request
// Ports: clk, rst_n (async active-low), start, funct, rs1_data, rs2_data, rd_in, flush
//        -> stall_req, busy, busy_rd, done, result, rd_out.
// Optional: define MUL_ZERO_SKIP_EN to retire ops with a zero operand in one cycle.
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int XLEN           = MUL_XLEN_DEF,
    parameter int BITS_PER_CYCLE = MUL_BPC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      funct,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic [4:0]      busy_rd,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int ITERS = mul_iters(XLEN, BITS_PER_CYCLE);
    localparam int CW    = $clog2(ITERS + 1);

`ifdef MUL_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    mul_state_e          state, state_next;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc, mcand, acc_next, prod_signed;
    logic [XLEN-1:0]     mplier;
    mul_funct_e          funct_q, f_in;
    logic                neg_q;
    logic [4:0]          rd_q;

    logic                accept, zero_op;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag, res_sel;

    // Operand magnitudes are full XLEN wide so -2^(XLEN-1) maps to 2^(XLEN-1).
    always_comb begin
        f_in    = mul_funct_e'(funct);
        a_neg   = (f_in == MUL_HSS || f_in == MUL_HSU) && rs1_data[XLEN-1];
        b_neg   = (f_in == MUL_HSS) && rs2_data[XLEN-1];
        a_mag   = a_neg ? -rs1_data : rs1_data;
        b_mag   = b_neg ? -rs2_data : rs2_data;
        zero_op = (rs1_data == '0) || (rs2_data == '0);
        accept  = (state == IDLE) && start && !flush;
    end

    mul_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .mbits    (mplier[BITS_PER_CYCLE-1:0]),
        .acc_next (acc_next)
    );

    // Sign is applied to the final step's sum so result can be registered on CALC exit.
    always_comb begin
        prod_signed = neg_q ? -acc_next : acc_next;
        res_sel     = (funct_q == MUL_LO) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (ZERO_SKIP && zero_op) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            funct_q <= MUL_LO;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= '0;
                        mcand   <= {{XLEN{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        cnt     <= CW'(ITERS);
                        funct_q <= f_in;
                        neg_q   <= a_neg ^ b_neg;
                        rd_q    <= rd_in;
                        if (ZERO_SKIP && zero_op) begin
                            result <= '0;
                            rd_out <= rd_in;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc    <= acc_next;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier >> BITS_PER_CYCLE;
                        cnt    <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            result <= res_sel;
                            rd_out <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_req = accept || (state == CALC);
    assign busy      = (state == CALC);
    assign busy_rd   = busy ? rd_q : 5'd0;
    assign done      = (state == DONE);

endmodule

// File: doc/mul_iter_unit.md
Name: mul_iter_unit

Overview:
- Multi-cycle RV32M multiply unit in the EX stage of the 5-stage RISC-V core.
- It is the producer side of the stall interface. The hazard detector only decides when dependents must wait on a Mul result; this block actually holds EX while the product is computed.
- It raises stall_req while busy, then presents result and rd for one cycle so forwarding and writeback proceed normally.
- Handles MUL, MULH, MULHSU and MULHU with iterative shift-add at BITS_PER_CYCLE bits per cycle.

Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYCLE, 2, multiplier bits retired per CALC cycle. Must divide XLEN; legal values 1, 2, 4.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a valid M-extension multiply; level, held while stalled.
- funct  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- rs1_data  in  XLEN  forwarded operand A.
- rs2_data  in  XLEN  forwarded operand B.
- rd_in  in  5  destination register of the issuing instruction.
- flush  in  1  kill the in-flight op (branch/jump flush of EX).
- stall_req  out  1  freeze IF/ID/EX this cycle.
- busy  out  1  state is CALC.
- busy_rd  out  5  latched rd while busy, 0 otherwise; feeds hazard detection.
- done  out  1  result valid this cycle, single-cycle pulse.
- result  out  XLEN  selected product half.
- rd_out  out  5  rd associated with result.

Behaviour:
- Reset (async, rst_n=0): state IDLE. stall_req, busy, done = 0. result, rd_out, busy_rd = 0. Accumulator cleared.
- States and transitions:
  - IDLE: if start && !flush → latch operands, funct and rd_in; go to CALC with iteration counter = XLEN/BITS_PER_CYCLE.
  - CALC: each cycle add the partial product of the low BITS_PER_CYCLE multiplier bits to the 2*XLEN accumulator, shift the multiplier right, decrement the counter. When the counter reaches 1 this cycle, go to DONE.
  - DONE: done=1, result and rd_out valid, stall_req=0. Return to IDLE unconditionally next cycle. start seen in DONE is the retiring instruction and is ignored.
- stall_req = (state==IDLE && start && !flush) || state==CALC. This is combinational, so the issuing cycle already stalls.
- Latency, with N = XLEN/BITS_PER_CYCLE:
  - start accepted at cycle 0; CALC occupies cycles 1..N; done at cycle N+1.
  - stall_req high for cycles 0..N.
  - Defaults: N=16, done at cycle 17.
- Back-to-back multiplies: the next instruction reaches EX in the cycle after DONE, finds IDLE, and is accepted there. No bubble beyond the DONE cycle.
- Arithmetic:
  - Operands are converted to magnitudes. rs1 is signed for MULH and MULHSU. rs2 is signed for MULH only.
  - Unsigned 2*XLEN product is computed; negated if the sign bits differ (signed operands only).
  - MUL returns the low XLEN bits; all others return the high XLEN bits.
  - The magnitude of -2^(XLEN-1) needs an XLEN-bit unsigned container, never XLEN-1 bits.
- flush: in CALC or in the IDLE accept cycle → state IDLE next cycle, no done pulse, stall_req low in the cycle after flush.
  - flush during DONE has no effect; the writeback suppression belongs to the pipeline.
- Simultaneous flush and start in IDLE: flush wins, nothing accepted.
- Reset asserted mid-CALC: immediate IDLE, all outputs at reset values, no done.
- result and rd_out hold their last value outside DONE; consumers qualify with done.

Optional Feature:
- MUL_ZERO_SKIP_EN, defined:
  - If either operand is 0 at accept, go IDLE → DONE directly with result 0.
  - done appears at cycle 1; stall_req is high only in cycle 0.
- Not defined: every op takes the full N+1 cycles regardless of operands.

Decomposition:
- Shared package mul_pkg:
  - funct encodings: MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU.
  - State encoding: IDLE, CALC, DONE.
  - Localparam for iteration count.
- One sub-module, mul_step: combinational radix-2^BITS_PER_CYCLE partial-product add of accumulator + multiplicand × low multiplier bits. The FSM and sign handling stay in mul_iter_unit.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), rd=5:
  - stall_req high cycles 0..16.
  - Cycle 17: done=1, result=0xFFFFFFEB, rd_out=5.
  - Cycle 18: IDLE.
- MULH 0x80000000 × 0x80000000 → result 0x40000000. Same operands with MUL → 0x00000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- flush at cycle 5 of CALC:
  - No done pulse; stall_req=0 from cycle 6; busy_rd=0.
  - A new start at cycle 7 completes normally at cycle 24.
- rst_n pulsed low at cycle 8 of CALC: outputs reset asynchronously the same cycle, and no done follows.
- Two back-to-back MULs (start held through stall, then next op): second accepted in the cycle after the first done; its done lands 18 cycles after the first done. With MUL_ZERO_SKIP_EN, MUL 0 × 0x1234 gives done at cycle 1 with result 0.
